// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-side signals of sram_arbiter. The arbiter takes the slave
// modport; a requester/SRAM model takes master.
interface sram_arbiter_if;
  logic        c_req, c_we, l_req, l_we;
  logic [19:0] c_addr, l_addr;
  logic [15:0] c_wdata, l_wdata;
  logic        c_gnt, l_gnt, c_done, l_done, busy;
  logic [15:0] rdata;
  logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM, Data_from_SRAM;
  logic        Data_oe;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, l_req, l_we, l_addr, l_wdata, Data_from_SRAM,
    output c_gnt, l_gnt, c_done, l_done, busy, rdata,
           Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_to_SRAM, Data_oe
  );
  modport master (
    output c_req, c_we, c_addr, c_wdata, l_req, l_we, l_addr, l_wdata, Data_from_SRAM,
    input  c_gnt, l_gnt, c_done, l_done, busy, rdata,
           Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_to_SRAM, Data_oe
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer for an external 1Mx16 async SRAM (CPU port c, loader port l).
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; otherwise port c has fixed priority.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  sram_arbiter_if.slave bus
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("sram_arbiter: WAIT_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        own_l, we_q, pick_l, any_req, active;
  logic [19:0] addr_q;
  logic [15:0] wdata_q, rdata_q;

  assign any_req = bus.c_req | bus.l_req;

`ifdef SRAM_ARB_RR_EN
  // last_l records the most recent winner; a tie goes to the other port
  logic last_l;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                          last_l <= 1'b1;
    else if (state == IDLE && any_req)   last_l <= pick_l;
  end

  assign pick_l = bus.l_req & (~bus.c_req | ~last_l);
`else
  assign pick_l = bus.l_req & ~bus.c_req;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      own_l   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 20'd0;
      wdata_q <= 16'd0;
      rdata_q <= 16'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (any_req) begin
          own_l   <= pick_l;
          we_q    <= pick_l ? bus.l_we    : bus.c_we;
          addr_q  <= pick_l ? bus.l_addr  : bus.c_addr;
          wdata_q <= pick_l ? bus.l_wdata : bus.c_wdata;
        end
        SETUP:  cnt <= 4'(WAIT_CYCLES - 1);
        ACCESS: begin
          if (cnt != 4'd0)  cnt     <= cnt - 4'd1;
          else if (!we_q)   rdata_q <= bus.Data_from_SRAM;
        end
        default: ;
      endcase
    end
  end

  // Strobes decode purely from registered state, so req never reaches an output
  assign active           = (state == SETUP) || (state == ACCESS);
  assign bus.busy         = (state != IDLE);
  assign bus.c_gnt        = (state != IDLE) & ~own_l;
  assign bus.l_gnt        = (state != IDLE) &  own_l;
  assign bus.c_done       = (state == DONE) & ~own_l;
  assign bus.l_done       = (state == DONE) &  own_l;
  assign bus.rdata        = rdata_q;
  assign bus.Mem_CE       = ~active;
  assign bus.Mem_UB       = ~active;
  assign bus.Mem_LB       = ~active;
  assign bus.Mem_OE       = ~(active & ~we_q);
  assign bus.Mem_WE       = ~((state == ACCESS) & we_q);
  assign bus.Data_oe      = active & we_q;
  assign bus.ADDR         = addr_q;
  assign bus.Data_to_SRAM = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: three instances (WAIT_CYCLES 2, 1, 15) with simple SRAM models.
module tb_sram_arbiter;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  sram_arbiter_if b2 ();
  sram_arbiter_if b1 ();
  sram_arbiter_if b15 ();

  sram_arbiter #(.WAIT_CYCLES(2))  dut2  (.Clk(Clk), .Reset(Reset), .bus(b2));
  sram_arbiter #(.WAIT_CYCLES(1))  dut1  (.Clk(Clk), .Reset(Reset), .bus(b1));
  sram_arbiter #(.WAIT_CYCLES(15)) dut15 (.Clk(Clk), .Reset(Reset), .bus(b15));

  // One-entry writable SRAM on dut2; other locations read as addr[15:0]^16'h5A5A
  logic [19:0] m_addr = 20'd0;
  logic [15:0] m_data = 16'd0;
  logic        m_vld  = 1'b0;
  always @(posedge Clk)
    if (!b2.Mem_CE && !b2.Mem_WE) begin
      m_addr <= b2.ADDR; m_data <= b2.Data_to_SRAM; m_vld <= 1'b1;
    end
  assign b2.Data_from_SRAM  = (b2.Mem_CE || b2.Mem_OE) ? 16'h0 :
                              (m_vld && m_addr == b2.ADDR) ? m_data : (b2.ADDR[15:0] ^ 16'h5A5A);
  assign b1.Data_from_SRAM  = (b1.Mem_CE || b1.Mem_OE) ? 16'h0 : (b1.ADDR[15:0] ^ 16'h5A5A);
  assign b15.Data_from_SRAM = (b15.Mem_CE || b15.Mem_OE) ? 16'h0 : (b15.ADDR[15:0] ^ 16'h5A5A);

  int n_chk = 0;
  int n_fail = 0;

  // {busy, c_gnt, l_gnt, c_done, l_done, Mem_CE, Mem_WE, Mem_OE, Data_oe}
  localparam logic [8:0] S_IDLE   = 9'b0_0000_1110;
  localparam logic [8:0] S_SET_W  = 9'b1_1000_0111;
  localparam logic [8:0] S_ACC_W  = 9'b1_1000_0011;
  localparam logic [8:0] S_RD_C   = 9'b1_1000_0100;
  localparam logic [8:0] S_DONE_C = 9'b1_1010_1110;

  function automatic logic [8:0] st2();
    return {b2.busy, b2.c_gnt, b2.l_gnt, b2.c_done, b2.l_done,
            b2.Mem_CE, b2.Mem_WE, b2.Mem_OE, b2.Data_oe};
  endfunction

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic init_inputs();
    b2.c_req = 0; b2.c_we = 0; b2.c_addr = 0; b2.c_wdata = 0;
    b2.l_req = 0; b2.l_we = 0; b2.l_addr = 0; b2.l_wdata = 0;
    b1.c_req = 0; b1.c_we = 0; b1.c_addr = 0; b1.c_wdata = 0;
    b1.l_req = 0; b1.l_we = 0; b1.l_addr = 0; b1.l_wdata = 0;
    b15.c_req = 0; b15.c_we = 0; b15.c_addr = 0; b15.c_wdata = 0;
    b15.l_req = 0; b15.l_we = 0; b15.l_addr = 0; b15.l_wdata = 0;
  endtask

  task automatic test_reset();
    #1;
    n_chk++; if (st2() !== S_IDLE) begin n_fail++; $display("FAIL rst_state: got %b want %b", st2(), S_IDLE); end
    n_chk++; if ({b2.rdata, b2.ADDR, b2.Data_to_SRAM} !== 52'd0) begin n_fail++;
      $display("FAIL rst_regs: rdata=%h addr=%h wd=%h want 0", b2.rdata, b2.ADDR, b2.Data_to_SRAM); end
    Reset = 1;
    tick();
    b2.c_req = 1; b2.c_we = 1; b2.c_addr = 20'h00012; b2.c_wdata = 16'h1234;
    tick();  // SETUP
    tick();  // first ACCESS cycle
    n_chk++; if (st2() !== S_ACC_W) begin n_fail++; $display("FAIL rst_pre_access: got %b want %b", st2(), S_ACC_W); end
    Reset = 0; #1;
    n_chk++; if (st2() !== S_IDLE) begin n_fail++; $display("FAIL rst_abort: got %b want %b", st2(), S_IDLE); end
    n_chk++; if ({b2.rdata, b2.ADDR} !== 36'd0) begin n_fail++;
      $display("FAIL rst_abort_regs: rdata=%h addr=%h want 0", b2.rdata, b2.ADDR); end
    b2.c_req = 0;
    tick();
    n_chk++; if (b2.c_done !== 1'b0) begin n_fail++; $display("FAIL rst_no_done: got %b want 0", b2.c_done); end
    Reset = 1;
    tick();
  endtask

  task automatic test_arbitration();
    logic [1:0]  eg [4];
    logic [15:0] ed [4];
`ifdef SRAM_ARB_RR_EN
    eg = '{2'b10, 2'b01, 2'b10, 2'b01};
    ed = '{16'h5B5A, 16'h5858, 16'h5B5A, 16'h5858};
`else
    eg = '{2'b10, 2'b10, 2'b10, 2'b10};
    ed = '{16'h5B5A, 16'h5B5A, 16'h5B5A, 16'h5B5A};
`endif
    b2.c_req = 1; b2.c_we = 0; b2.c_addr = 20'h00100;
    b2.l_req = 1; b2.l_we = 0; b2.l_addr = 20'h00200;
    for (int i = 0; i < 4; i++) begin
      tick();  // SETUP
      n_chk++; if ({b2.c_gnt, b2.l_gnt} !== eg[i]) begin n_fail++;
        $display("FAIL arb_gnt[%0d]: got %b want %b", i, {b2.c_gnt, b2.l_gnt}, eg[i]); end
      tick(); tick(); tick();  // ACCESS, ACCESS, DONE
      n_chk++; if ({b2.c_done, b2.l_done, b2.rdata} !== {eg[i], ed[i]}) begin n_fail++;
        $display("FAIL arb_done[%0d]: got done=%b rdata=%h want done=%b rdata=%h",
                 i, {b2.c_done, b2.l_done}, b2.rdata, eg[i], ed[i]); end
      if (i == 3) begin b2.c_req = 0; b2.l_req = 0; end
      tick();  // IDLE
    end
  endtask

  task automatic test_write();
    logic [8:0]  exp [4];
    logic [15:0] rd_keep;
    exp = '{S_SET_W, S_ACC_W, S_ACC_W, S_DONE_C};
`ifdef SRAM_ARB_RR_EN
    rd_keep = 16'h5858;
`else
    rd_keep = 16'h5B5A;
`endif
    b2.c_req = 1; b2.c_we = 1; b2.c_addr = 20'h00012; b2.c_wdata = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (st2() !== exp[i]) begin n_fail++;
        $display("FAIL wr_cycle[%0d]: got %b want %b", i + 1, st2(), exp[i]); end
    end
    n_chk++; if ({b2.ADDR, b2.Data_to_SRAM, b2.rdata} !== {20'h00012, 16'hBEEF, rd_keep}) begin n_fail++;
      $display("FAIL wr_done_regs: addr=%h wd=%h rdata=%h want 00012 beef %h",
               b2.ADDR, b2.Data_to_SRAM, b2.rdata, rd_keep); end
    b2.c_req = 0;
    tick();
    n_chk++; if (st2() !== S_IDLE) begin n_fail++; $display("FAIL wr_idle: got %b want %b", st2(), S_IDLE); end
  endtask

  task automatic test_read();
    int  cyc = 0, oe_lo = 0, we_lo = 0;
    logic seen = 1'b0;
    b2.c_req = 1; b2.c_we = 0; b2.c_addr = 20'h00012; b2.c_wdata = 16'h0000;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      if (!b2.Mem_OE) oe_lo++;
      if (!b2.Mem_WE) we_lo++;
      if (i == 1 && st2() !== S_RD_C) begin n_chk++; n_fail++;
        $display("FAIL rd_setup: got %b want %b", st2(), S_RD_C); end
      if (b2.c_done) begin seen = 1'b1; cyc = i; end
    end
    n_chk++; if (cyc != 4) begin n_fail++; $display("FAIL rd_latency: got %0d want 4", cyc); end
    n_chk++; if (oe_lo != 3 || we_lo != 0) begin n_fail++;
      $display("FAIL rd_strobes: oe_low=%0d we_low=%0d want 3 0", oe_lo, we_lo); end
    n_chk++; if (b2.rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: got %h want beef", b2.rdata); end
    b2.c_req = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    b2.c_req = 1; b2.c_we = 0; b2.c_addr = 20'h00012;
    tick(); tick(); tick(); tick();  // SETUP, ACCESS x2, DONE
    n_chk++; if (st2() !== S_DONE_C) begin n_fail++; $display("FAIL b2b_done1: got %b want %b", st2(), S_DONE_C); end
    tick();
    n_chk++; if (st2() !== S_IDLE) begin n_fail++; $display("FAIL b2b_gap: got %b want %b", st2(), S_IDLE); end
    tick();
    n_chk++; if (st2() !== S_RD_C) begin n_fail++; $display("FAIL b2b_setup2: got %b want %b", st2(), S_RD_C); end
    tick(); tick(); tick();
    n_chk++; if ({b2.c_done, b2.rdata} !== {1'b1, 16'hBEEF}) begin n_fail++;
      $display("FAIL b2b_done2: done=%b rdata=%h want 1 beef", b2.c_done, b2.rdata); end
    b2.c_req = 0;
    tick();
  endtask

  task automatic test_wait_cycles();
    int c1 = 0, c15 = 0;
    b1.l_req = 1; b1.l_we = 0; b1.l_addr = 20'hFFFFF;
    for (int i = 1; i <= 40 && c1 == 0; i++) begin tick(); if (b1.l_done) c1 = i; end
    n_chk++; if (c1 != 3) begin n_fail++; $display("FAIL wait1_latency: got %0d want 3", c1); end
    n_chk++; if (b1.rdata !== 16'hA5A5) begin n_fail++; $display("FAIL wait1_data: got %h want a5a5", b1.rdata); end
    b1.l_req = 0;
    tick();
    b15.l_req = 1; b15.l_we = 0; b15.l_addr = 20'hFFFFF;
    for (int i = 1; i <= 40 && c15 == 0; i++) begin tick(); if (b15.l_done) c15 = i; end
    n_chk++; if (c15 != 17) begin n_fail++; $display("FAIL wait15_latency: got %0d want 17", c15); end
    n_chk++; if (b15.rdata !== 16'hA5A5) begin n_fail++; $display("FAIL wait15_data: got %h want a5a5", b15.rdata); end
    b15.l_req = 0;
    tick();
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_arbitration();
    test_write();
    test_read();
    test_back_to_back();
    test_wait_cycles();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
